// File: rtl/pwm_pkg.sv
// Shared definitions for the complementary PWM channel: default widths and
// the dead-time state machine encoding.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DT_W_DEF  = 8;

    // OFF: both gates low, waiting for the channel to run.
    // DT_TO_x: both gates low while the dead-time counter drains before turning x on.
    // x_ON: gate x driven.
    typedef enum logic [2:0] {
        OFF      = 3'd0,
        DT_TO_HS = 3'd1,
        HS_ON    = 3'd2,
        DT_TO_LS = 3'd3,
        LS_ON    = 3'd4
    } dt_state_t;

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// Dead-time insertion for one high-side/low-side gate pair. Turns the raw
// PWM level into two gate drives with both gates low for max(dt_act_i,1)
// cycles around every transition. The gates are registered from the next
// state, so at most one of them can be high in any cycle.
module pwm_deadtime_fsm
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            raw_i,
    input  logic            run_i,
    input  logic [DT_W-1:0] dt_act_i,
    output logic            hs_gate_o,
    output logic            ls_gate_o
);

    dt_state_t       state_q, state_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic            hs_q, hs_d;
    logic            ls_q, ls_d;

    // Next-state logic. dt_cnt holds the dead cycles still owed, counting the
    // current one, so a loaded value of 0 or 1 gives exactly one dead cycle.
    // A raw flip during a dead phase restarts the dead phase toward the other
    // gate.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        if (!run_i) begin
            state_d  = OFF;
            dt_cnt_d = '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d  = raw_i ? DT_TO_HS : DT_TO_LS;
                    dt_cnt_d = dt_act_i;
                end
                DT_TO_HS: begin
                    if (!raw_i) begin
                        state_d  = DT_TO_LS;
                        dt_cnt_d = dt_act_i;
                    end else if (dt_cnt_q <= DT_W'(1)) begin
                        state_d  = HS_ON;
                        dt_cnt_d = '0;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_W'(1);
                    end
                end
                HS_ON: begin
                    if (!raw_i) begin
                        state_d  = DT_TO_LS;
                        dt_cnt_d = dt_act_i;
                    end
                end
                DT_TO_LS: begin
                    if (raw_i) begin
                        state_d  = DT_TO_HS;
                        dt_cnt_d = dt_act_i;
                    end else if (dt_cnt_q <= DT_W'(1)) begin
                        state_d  = LS_ON;
                        dt_cnt_d = '0;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_W'(1);
                    end
                end
                LS_ON: begin
                    if (raw_i) begin
                        state_d  = DT_TO_HS;
                        dt_cnt_d = dt_act_i;
                    end
                end
                default: begin
                    state_d  = OFF;
                    dt_cnt_d = '0;
                end
            endcase
        end
        hs_d = (state_d == HS_ON);
        ls_d = (state_d == LS_ON);
    end

    // State, dead-time counter and gate registers; reset parks both gates low.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= OFF;
            dt_cnt_q <= '0;
            hs_q     <= 1'b0;
            ls_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            hs_q     <= hs_d;
            ls_q     <= ls_d;
        end
    end

    assign hs_gate_o = hs_q;
    assign ls_gate_o = ls_q;

endmodule

// File: rtl/pwm_deadtime_channel.sv
// One complementary PWM channel: period counter, double-buffered
// period/duty/dead-time configuration, sticky fault shutdown, and a
// dead-time gate driver. New configuration only reaches the active
// registers at a period boundary, or immediately while the channel is idle.
module pwm_deadtime_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DT_W  = DT_W_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic [DT_W-1:0]  deadtime_i,
    input  logic             cfg_load_i,
    input  logic             fault_i,
    input  logic             fault_clr_i,
    output logic             hs_gate_o,
    output logic             ls_gate_o,
    output logic             cycle_start_o,
    output logic             fault_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [DT_W-1:0]  dt_act_q, dt_act_d;
    logic [CNT_W-1:0] period_pend_q, period_pend_d;
    logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
    logic [DT_W-1:0]  dt_pend_q, dt_pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             fault_q, fault_d;

    logic running;
    logic fsm_run;
    logic raw;
    logic wrap;
    logic xfer;

    // A fault arriving this cycle stops the counter and the gates at the same
    // edge that latches it, ahead of enable and configuration.
    assign running = enable_i && !fault_q;
    assign fsm_run = running && !fault_i;
    assign raw     = (cnt_q < duty_act_q);
    assign wrap    = (cnt_q == period_act_q);
    assign xfer    = pend_valid_q && (wrap || !running);

    // Counter, configuration double-buffer and sticky fault next-state.
    always_comb begin
        fault_d = fault_i || (fault_q && !fault_clr_i);

        cnt_d = '0;
        if (fsm_run) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end

        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        dt_act_d     = dt_act_q;
        if (xfer) begin
            period_act_d = period_pend_q;
            duty_act_d   = duty_pend_q;
            dt_act_d     = dt_pend_q;
        end

        // A load coinciding with a transfer refills pending and keeps it valid.
        period_pend_d = period_pend_q;
        duty_pend_d   = duty_pend_q;
        dt_pend_d     = dt_pend_q;
        pend_valid_d  = pend_valid_q;
        if (cfg_load_i) begin
            period_pend_d = period_i;
            duty_pend_d   = duty_i;
            dt_pend_d     = deadtime_i;
            pend_valid_d  = 1'b1;
        end else if (xfer) begin
            pend_valid_d = 1'b0;
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cnt_q         <= '0;
            period_act_q  <= '0;
            duty_act_q    <= '0;
            dt_act_q      <= '0;
            period_pend_q <= '0;
            duty_pend_q   <= '0;
            dt_pend_q     <= '0;
            pend_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            period_act_q  <= period_act_d;
            duty_act_q    <= duty_act_d;
            dt_act_q      <= dt_act_d;
            period_pend_q <= period_pend_d;
            duty_pend_q   <= duty_pend_d;
            dt_pend_q     <= dt_pend_d;
            pend_valid_q  <= pend_valid_d;
            fault_q       <= fault_d;
        end
    end

    pwm_deadtime_fsm #(
        .DT_W (DT_W)
    ) u_fsm (
        .clk_i     (wb_clk_i),
        .rst_n_i   (wb_rst_n_i),
        .raw_i     (raw),
        .run_i     (fsm_run),
        .dt_act_i  (dt_act_q),
        .hs_gate_o (hs_gate_o),
        .ls_gate_o (ls_gate_o)
    );

    // Qualified by the reset input so the pulse stays low while reset is held,
    // even though the counter already reads 0 and enable may still be high.
    assign cycle_start_o = wb_rst_n_i && running && (cnt_q == '0);
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_pwm_deadtime_channel.sv
// Bench for pwm_deadtime_channel. Each drive step pushes the expected
// {hs, ls, cycle_start, fault} for the coming edge, computed by a small
// behavioural model: a gate turns on once raw has held the same level for
// max(deadtime,1)+1 consecutive running samples. Tasks add scenario-specific
// pattern checks derived by hand.
module tb_pwm_deadtime_channel;

    localparam int CNT_W = 16;
    localparam int DT_W  = 8;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_n_i = 1'b0;
    logic             enable_i = 1'b0;
    logic [CNT_W-1:0] period_i = '0;
    logic [CNT_W-1:0] duty_i = '0;
    logic [DT_W-1:0]  deadtime_i = '0;
    logic             cfg_load_i = 1'b0;
    logic             fault_i = 1'b0;
    logic             fault_clr_i = 1'b0;
    logic             hs_gate_o;
    logic             ls_gate_o;
    logic             cycle_start_o;
    logic             fault_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    // Bench-side configuration bus and enable
    int   cfg_per = 0;
    int   cfg_duty = 0;
    int   cfg_dt = 0;
    logic en_r = 1'b0;

    // Reference model state
    int   m_cnt = 0, m_per = 0, m_duty = 0, m_dt = 0;
    int   p_per = 0, p_duty = 0, p_dt = 0;
    logic m_pv = 1'b0, m_fault = 1'b0, m_last = 1'b0;
    int   m_len = 0, m_d = 1;

    pwm_deadtime_channel #(
        .CNT_W (CNT_W),
        .DT_W  (DT_W)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_n_i    (wb_rst_n_i),
        .enable_i      (enable_i),
        .period_i      (period_i),
        .duty_i        (duty_i),
        .deadtime_i    (deadtime_i),
        .cfg_load_i    (cfg_load_i),
        .fault_i       (fault_i),
        .fault_clr_i   (fault_clr_i),
        .hs_gate_o     (hs_gate_o),
        .ls_gate_o     (ls_gate_o),
        .cycle_start_o (cycle_start_o),
        .fault_o       (fault_o)
    );

    // Clock
    always #5 wb_clk_i = ~wb_clk_i;

    // Gates must never overlap, checked away from the active edge
    always @(negedge wb_clk_i) begin
        n_tests++;
        if (hs_gate_o && ls_gate_o) begin
            n_fail++;
            $display("FAIL gate_overlap t=%0t hs=%b ls=%b required not both 1", $time, hs_gate_o, ls_gate_o);
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    // Drive one cycle of stimulus, push the model's expectation for the
    // following edge, then wait until just after that edge.
    task automatic drive_cycle(input logic ld, input logic fi, input logic fc, input logic rn);
        logic running, fsm_run, raw, wrap, xfer;
        logic [3:0] e;
        enable_i    = en_r;
        cfg_load_i  = ld;
        period_i    = CNT_W'(cfg_per);
        duty_i      = CNT_W'(cfg_duty);
        deadtime_i  = DT_W'(cfg_dt);
        fault_i     = fi;
        fault_clr_i = fc;
        wb_rst_n_i  = rn;
        if (!rn) begin
            m_cnt = 0; m_per = 0; m_duty = 0; m_dt = 0;
            p_per = 0; p_duty = 0; p_dt = 0;
            m_pv = 1'b0; m_fault = 1'b0; m_len = 0;
        end else begin
            running = en_r && !m_fault;
            fsm_run = running && !fi;
            raw     = (m_cnt < m_duty);
            wrap    = running && (m_cnt == m_per);
            xfer    = m_pv && (wrap || !running);
            if (fsm_run) begin
                if (m_len > 0 && raw == m_last) begin
                    m_len++;
                end else begin
                    m_len  = 1;
                    m_last = raw;
                    m_d    = (m_dt > 0) ? m_dt : 1;
                end
            end else begin
                m_len = 0;
            end
            if (fsm_run) m_cnt = (m_cnt == m_per) ? 0 : m_cnt + 1;
            else m_cnt = 0;
            if (xfer) begin
                m_per = p_per; m_duty = p_duty; m_dt = p_dt;
            end
            if (ld) begin
                p_per = cfg_per; p_duty = cfg_duty; p_dt = cfg_dt;
                m_pv = 1'b1;
            end else if (xfer) begin
                m_pv = 1'b0;
            end
            m_fault = fi || (m_fault && !fc);
        end
        e[3] = rn && (m_len >= m_d + 1) && m_last;
        e[2] = rn && (m_len >= m_d + 1) && !m_last;
        e[1] = rn && en_r && !m_fault && (m_cnt == 0);
        e[0] = m_fault;
        exp_q.push_back(e);
        @(posedge wb_clk_i);
        #1;
    endtask

    // Load a configuration with the channel idle and let it transfer
    task automatic configure(input int per, input int du, input int dt);
        logic [3:0] dummy;
        cfg_per = per; cfg_duty = du; cfg_dt = dt;
        en_r = 1'b0;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        dummy = exp_q.pop_front();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        dummy = exp_q.pop_front();
    endtask

    task automatic test_reset();
        logic [3:0] got, e;
        en_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_sb k=%0d got=%b required=%b", k, got, e);
            end
            n_tests++;
            if (got !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d got=%b required=0000", k, got);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] got, e;
        logic [2:0] pat;
        int hs_n = 0, ls_n = 0, cs_n = 0;
        configure(9, 3, 2);
        en_r = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL basic_sb k=%0d got=%b required=%b", k, got, e);
            end
            if (k >= 11) begin
                pat = {(k % 10 == 3), (k % 10 >= 6) || (k % 10 == 0), (k % 10 == 0)};
                n_tests++;
                if (got[3:1] !== pat) begin
                    n_fail++;
                    $display("FAIL basic_pattern k=%0d got=%b required=%b", k, got[3:1], pat);
                end
            end
            if (k >= 21 && k <= 30) begin
                hs_n += int'(hs_gate_o);
                ls_n += int'(ls_gate_o);
                cs_n += int'(cycle_start_o);
            end
        end
        n_tests++;
        if (hs_n != 1 || ls_n != 5 || cs_n != 1) begin
            n_fail++;
            $display("FAIL basic_counts hs=%0d ls=%0d cs=%0d required 1/5/1", hs_n, ls_n, cs_n);
        end
    endtask

    // Runs straight after test_basic: the counter is at 0 on entry
    task automatic test_double_buffer();
        logic [3:0] got, e;
        logic [1:0] pat;
        for (int k = 41; k <= 70; k++) begin
            if (k == 45) cfg_duty = 6;
            drive_cycle(k == 45, 1'b0, 1'b0, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL dbuf_sb k=%0d got=%b required=%b", k, got, e);
            end
            if (k <= 50) pat = {(k % 10 == 3), (k % 10 >= 6) || (k % 10 == 0)};
            else pat = {(k % 10 >= 3) && (k % 10 <= 6), (k % 10 == 9) || (k % 10 == 0)};
            n_tests++;
            if (got[3:2] !== pat) begin
                n_fail++;
                $display("FAIL dbuf_pattern k=%0d got=%b required=%b", k, got[3:2], pat);
            end
        end
    endtask

    task automatic test_duty_zero();
        logic [3:0] got, e;
        configure(9, 0, 2);
        en_r = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL duty0_sb k=%0d got=%b required=%b", k, got, e);
            end
            n_tests++;
            if (got[3:2] !== {1'b0, (k >= 3)}) begin
                n_fail++;
                $display("FAIL duty0_gates k=%0d got=%b required=%b", k, got[3:2], {1'b0, (k >= 3)});
            end
        end
    endtask

    task automatic test_duty_full();
        logic [3:0] got, e;
        configure(9, 10, 2);
        en_r = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL dutyfull_sb k=%0d got=%b required=%b", k, got, e);
            end
            n_tests++;
            if (got[3:1] !== {(k >= 3), 1'b0, (k % 10 == 0)}) begin
                n_fail++;
                $display("FAIL dutyfull_pattern k=%0d got=%b required=%b", k, got[3:1], {(k >= 3), 1'b0, (k % 10 == 0)});
            end
        end
    endtask

    task automatic test_deadtime_zero();
        logic [3:0] got, e;
        logic [1:0] pat;
        configure(9, 3, 0);
        en_r = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL dt0_sb k=%0d got=%b required=%b", k, got, e);
            end
            pat = {(k % 10 == 2) || (k % 10 == 3), (k >= 5) && ((k % 10 >= 5) || (k % 10 == 0))};
            n_tests++;
            if (got[3:2] !== pat) begin
                n_fail++;
                $display("FAIL dt0_pattern k=%0d got=%b required=%b", k, got[3:2], pat);
            end
        end
    endtask

    task automatic test_fault();
        logic [3:0] got, e;
        logic fi, fc;
        configure(9, 6, 2);
        en_r = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            fi = (k == 5) || (k == 6);
            fc = (k == 6) || (k == 8);
            drive_cycle(1'b0, fi, fc, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fault_sb k=%0d got=%b required=%b", k, got, e);
            end
            if (k == 4) begin
                n_tests++;
                if (hs_gate_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fault_pre_hs got=%b required=1", hs_gate_o);
                end
            end
            if (k == 5) begin
                n_tests++;
                if ({hs_gate_o, ls_gate_o, fault_o} !== 3'b001 || dut.cnt_q !== '0) begin
                    n_fail++;
                    $display("FAIL fault_entry hs/ls/flt=%b cnt=%0d required 001 cnt=0", {hs_gate_o, ls_gate_o, fault_o}, dut.cnt_q);
                end
            end
            if (k == 6 || k == 7) begin
                n_tests++;
                if (fault_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fault_sticky k=%0d got=%b required=1", k, fault_o);
                end
            end
            if (k == 8) begin
                n_tests++;
                if ({fault_o, cycle_start_o} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL fault_clear flt/cs=%b required=01", {fault_o, cycle_start_o});
                end
            end
            if (k >= 8 && k <= 11) begin
                n_tests++;
                if ({hs_gate_o, ls_gate_o} !== {(k == 11), 1'b0}) begin
                    n_fail++;
                    $display("FAIL fault_restart k=%0d got=%b required=%b", k, {hs_gate_o, ls_gate_o}, {(k == 11), 1'b0});
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] got, e;
        logic [1:0] pat;
        configure(9, 1, 3);
        en_r = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL abort_sb k=%0d got=%b required=%b", k, got, e);
            end
            pat = {1'b0, (k >= 5) && ((k % 10 >= 5) || (k % 10 == 0))};
            n_tests++;
            if (got[3:2] !== pat) begin
                n_fail++;
                $display("FAIL abort_pattern k=%0d got=%b required=%b", k, got[3:2], pat);
            end
        end
    endtask

    task automatic test_enable_deassert();
        logic [3:0] got, e;
        configure(9, 6, 2);
        en_r = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            if (k == 15) en_r = 1'b0;
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL enable_sb k=%0d got=%b required=%b", k, got, e);
            end
            if (k == 14) begin
                n_tests++;
                if (hs_gate_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL enable_pre_hs got=%b required=1", hs_gate_o);
                end
            end
            if (k >= 15) begin
                n_tests++;
                if (got[3:1] !== 3'b000 || dut.cnt_q !== '0) begin
                    n_fail++;
                    $display("FAIL enable_off k=%0d hs/ls/cs=%b cnt=%0d required 000 cnt=0", k, got[3:1], dut.cnt_q);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, e;
        configure(9, 6, 2);
        en_r = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, k != 5);
            got = {hs_gate_o, ls_gate_o, cycle_start_o, fault_o};
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rstmid_sb k=%0d got=%b required=%b", k, got, e);
            end
            if (k == 4) begin
                n_tests++;
                if (hs_gate_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_pre_hs got=%b required=1", hs_gate_o);
                end
            end
            if (k == 5) begin
                n_tests++;
                if (got !== 4'b0000 || dut.period_act_q !== '0 || dut.duty_act_q !== '0 || dut.dt_act_q !== '0) begin
                    n_fail++;
                    $display("FAIL rstmid_clear out=%b per=%0d duty=%0d dt=%0d required all 0", got, dut.period_act_q, dut.duty_act_q, dut.dt_act_q);
                end
            end
            if (k >= 6) begin
                n_tests++;
                if (got[3:1] !== {1'b0, (k >= 7), 1'b1}) begin
                    n_fail++;
                    $display("FAIL rstmid_after k=%0d got=%b required=%b", k, got[3:1], {1'b0, (k >= 7), 1'b1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_buffer();
        test_duty_zero();
        test_duty_full();
        test_deadtime_zero();
        test_fault();
        test_abort();
        test_enable_deassert();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
